// File: rtl/decoder_input_sequencer_pkg.sv
// Shared definitions for the decoder input sequencer: sequencer states,
// decoder field positions and the dual-rail bus geometry.
package decoder_input_sequencer_pkg;

    typedef enum logic [1:0] {
        RST_IDLE = 2'd0,
        FETCH    = 2'd1,
        EXEC     = 2'd2
    } seq_state_t;

    // Logical decoder fields, one rail pair each.
    localparam int NUM_FIELDS = 13;
    localparam int NUM_RAILS  = 2 * NUM_FIELDS;
    localparam int F_INT      = 0;   // interrupt dispatch
    localparam int F_CB       = 1;   // CB prefix seen
    localparam int F_IR_LO    = 2;   // IR bit 7 sits here, IR bit 0 at F_IR_LO+7
    localparam int F_STEP_LO  = 10;  // step bit 0 sits here, step bit 2 at F_STEP_LO+2

    localparam logic [7:0] CB_PREFIX = 8'hCB;
    localparam logic [2:0] STEP_MAX  = 3'd7;

endpackage

// File: rtl/decoder_input_sequencer_if.sv
// Opcode fetch handshake between the instruction fetch unit (master)
// and the sequencer (slave).
interface decoder_input_sequencer_if;
    logic [7:0] opcode;
    logic       opcode_valid;
    logic       opcode_ready;

    modport master (
        output opcode,
        output opcode_valid,
        input  opcode_ready
    );

    modport slave (
        input  opcode,
        input  opcode_valid,
        output opcode_ready
    );
endinterface

// File: rtl/decoder_input_sequencer_dual_rail_enc.sv
// Dual-rail encoder: every logical field becomes a complementary rail pair
// (even rail = inverted, odd rail = true). With the enable low every rail
// is forced low so no decoder line is active.
module dual_rail_enc
    import decoder_input_sequencer_pkg::*;
(
    input  logic [NUM_FIELDS-1:0] fields,
    input  logic                  en,
    output logic [NUM_RAILS-1:0]  rails
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_pair
            assign rails[2*gi]   = en & ~fields[gi];
            assign rails[2*gi+1] = en &  fields[gi];
        end
    endgenerate

endmodule

// File: rtl/decoder_input_sequencer.sv
// Decoder input sequencer: accepts opcode bytes (with CB prefix handling),
// tracks the M-cycle step of the executing instruction and presents the
// instruction context to the decoder as a registered dual-rail bus.
module decoder_input_sequencer
    import decoder_input_sequencer_pkg::*;
(
    input  logic                        CLK,
    input  logic                        nRESET,
    decoder_input_sequencer_if.slave    op,
    input  logic                        int_req,
    input  logic                        step_adv,
    input  logic                        last_cycle,
    input  logic                        flush,
    output logic [NUM_RAILS-1:0]        a,
    output logic                        in_exec,
    output logic [2:0]                  step,
    output logic                        seq_err
);

    seq_state_t            state_reg, state_next;
    logic [7:0]            ir_reg, ir_next;
    logic                  cb_reg, cb_next;
    logic                  int_reg, int_next;
    logic [2:0]            step_reg, step_next;
    logic                  err_reg, err_next;
    logic [NUM_RAILS-1:0]  a_reg;

    logic [NUM_FIELDS-1:0] fields_next;
    logic [NUM_RAILS-1:0]  rails_next;
    logic                  handshake;

    assign op.opcode_ready = (state_reg == FETCH);
    assign handshake       = op.opcode_valid & op.opcode_ready;

    // State and context registers; reset clears everything immediately.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_reg <= RST_IDLE;
            ir_reg    <= 8'h00;
            cb_reg    <= 1'b0;
            int_reg   <= 1'b0;
            step_reg  <= 3'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
            cb_reg    <= cb_next;
            int_reg   <= int_next;
            step_reg  <= step_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic: flush dominates, then fetch handshake or step advance.
    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        cb_next    = cb_reg;
        int_next   = int_reg;
        step_next  = step_reg;
        err_next   = err_reg;

        if (flush) begin
            // Abort to fetch; any opcode offered this cycle is dropped.
            state_next = FETCH;
            cb_next    = 1'b0;
            int_next   = 1'b0;
            step_next  = 3'd0;
        end else begin
            unique case (state_reg)
                RST_IDLE: begin
                    state_next = FETCH;
                end
                FETCH: begin
                    if (handshake) begin
                        ir_next   = op.opcode;
                        step_next = 3'd0;
                        if ((op.opcode == CB_PREFIX) && !cb_reg) begin
                            // Prefix byte: remember it and keep fetching.
                            cb_next = 1'b1;
                        end else begin
                            int_next   = int_req;
                            state_next = EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (step_adv) begin
                        if (last_cycle) begin
                            // Instruction complete; IR keeps the last opcode.
                            state_next = FETCH;
                            cb_next    = 1'b0;
                            int_next   = 1'b0;
                            step_next  = 3'd0;
                        end else if (step_reg == STEP_MAX) begin
                            // Ran past the last step: saturate and flag it.
                            err_next = 1'b1;
                        end else begin
                            step_next = step_reg + 3'd1;
                        end
                    end
                end
                default: begin
                    state_next = RST_IDLE;
                end
            endcase
        end
    end

    // Assemble the decoder fields from the upcoming context.
    assign fields_next[F_INT] = int_next;
    assign fields_next[F_CB]  = cb_next;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ir_field
            assign fields_next[F_IR_LO+gi] = ir_next[7-gi];
        end
        for (gi = 0; gi < 3; gi++) begin : g_step_field
            assign fields_next[F_STEP_LO+gi] = step_next[gi];
        end
    endgenerate

    dual_rail_enc u_enc (
        .fields (fields_next),
        .en     (state_next != RST_IDLE),
        .rails  (rails_next)
    );

    // Registered decoder bus so it changes only on clock edges.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            a_reg <= '0;
        end else begin
            a_reg <= rails_next;
        end
    end

    assign a       = a_reg;
    assign in_exec = (state_reg == EXEC);
    assign step    = step_reg;
    assign seq_err = err_reg;

endmodule

// File: tb/tb_decoder_input_sequencer.sv
// Self-checking bench for decoder_input_sequencer: directed scenarios plus
// randomized traffic compared against an instruction-level reference model.
module tb_decoder_input_sequencer;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        int_req, step_adv, last_cycle, flush;
    logic [25:0] a;
    logic        in_exec;
    logic [2:0]  step;
    logic        seq_err;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = idle after reset, 1 = fetching, 2 = executing.
    int         m_mode;
    logic [7:0] m_ir;
    logic       m_cb, m_int, m_err;
    int         m_step;

    always #5 CLK = ~CLK;

    decoder_input_sequencer_if op_if ();

    decoder_input_sequencer dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .op         (op_if.slave),
        .int_req    (int_req),
        .step_adv   (step_adv),
        .last_cycle (last_cycle),
        .flush      (flush),
        .a          (a),
        .in_exec    (in_exec),
        .step       (step),
        .seq_err    (seq_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected bus: field list laid out as complementary pairs.
    function automatic logic [25:0] model_bus();
        logic [12:0] f;
        logic [25:0] r;
        logic [2:0]  s;
        if (m_mode == 0) return 26'd0;
        s    = m_step[2:0];
        f[0] = m_int;
        f[1] = m_cb;
        for (int k = 0; k < 8; k++) f[2+k] = m_ir[7-k];
        for (int k = 0; k < 3; k++) f[10+k] = s[k];
        for (int i = 0; i < 13; i++) begin
            r[2*i]   = ~f[i];
            r[2*i+1] = f[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ir = 8'h00; m_cb = 0; m_int = 0; m_step = 0; m_err = 0;
    endtask

    task automatic model_edge();
        if (flush) begin
            m_mode = 1; m_cb = 0; m_int = 0; m_step = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (op_if.opcode_valid) begin
                m_ir   = op_if.opcode;
                m_step = 0;
                if (op_if.opcode == 8'hCB && !m_cb) m_cb = 1;
                else begin
                    m_int  = int_req;
                    m_mode = 2;
                end
            end
        end else if (step_adv) begin
            if (last_cycle) begin
                m_mode = 1; m_cb = 0; m_int = 0; m_step = 0;
            end else if (m_step == 7) m_err = 1;
            else m_step = m_step + 1;
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".a"}, 32'(a), 32'(model_bus()));
        check_val({tag, ".ready"}, 32'(op_if.opcode_ready), 32'(m_mode == 1));
        check_val({tag, ".in_exec"}, 32'(in_exec), 32'(m_mode == 2));
        check_val({tag, ".step"}, 32'(step), 32'(m_step));
        check_val({tag, ".seq_err"}, 32'(seq_err), 32'(m_err));
    endtask

    task automatic drive(input logic v, input logic [7:0] opc, input logic ir,
                         input logic adv, input logic last, input logic fl);
        op_if.opcode_valid = v;
        op_if.opcode       = opc;
        int_req            = ir;
        step_adv           = adv;
        last_cycle         = last;
        flush              = fl;
    endtask

    task automatic cycle(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between clock edges, released before the next edge.
    task automatic async_reset(input string tag);
        nRESET = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        check_val({tag, ".a_zero"}, 32'(a), 32'd0);
        nRESET = 1'b1;
    endtask

    initial begin
        drive(0, 8'h00, 0, 0, 0, 0);
        model_reset();
        #2;
        check_all("reset");
        #20;
        nRESET = 1'b1;
        cycle("release");

        // Plain opcode with no interrupt.
        drive(1, 8'h3E, 0, 0, 0, 0);
        cycle("op3e");
        check_val("op3e.const_a", 32'(a), 32'h156AA55);
        drive(0, 8'h00, 0, 1, 1, 0);
        cycle("op3e.done");

        // CB prefix then 0x37.
        drive(1, 8'hCB, 0, 0, 0, 0);
        cycle("cb");
        check_val("cb.a3", 32'(a[3]), 32'd1);
        check_val("cb.a2", 32'(a[2]), 32'd0);
        drive(1, 8'h37, 0, 0, 0, 0);
        cycle("cb37");
        check_val("cb37.a3", 32'(a[3]), 32'd1);
        drive(0, 8'h00, 0, 1, 1, 0);
        cycle("cb37.done");

        // Interrupt dispatch: three steps, last one ends the instruction.
        drive(1, 8'h00, 1, 0, 0, 0);
        cycle("int");
        check_val("int.a1", 32'(a[1]), 32'd1);
        drive(0, 8'h00, 0, 1, 0, 0);
        cycle("int.s1");
        cycle("int.s2");
        drive(0, 8'h00, 0, 1, 1, 0);
        cycle("int.end");
        check_val("int.end.a1", 32'(a[1]), 32'd0);
        check_val("int.end.a0", 32'(a[0]), 32'd1);

        // Flush coinciding with a handshake after a CB prefix.
        drive(1, 8'hCB, 0, 0, 0, 0);
        cycle("fl.cb");
        drive(1, 8'h55, 0, 0, 0, 1);
        cycle("fl.drop");

        // Step saturation and sticky error.
        drive(1, 8'h12, 0, 0, 0, 0);
        cycle("sat.op");
        for (int i = 0; i < 8; i++) begin
            drive(0, 8'h00, 0, 1, 0, 0);
            cycle("sat.adv");
        end
        drive(0, 8'h00, 0, 1, 1, 0);
        cycle("sat.end");
        drive(0, 8'h00, 0, 0, 0, 1);
        cycle("sat.flush");

        // Asynchronous reset mid-execution at step 2.
        drive(1, 8'h21, 0, 0, 0, 0);
        cycle("ar.op");
        drive(0, 8'h00, 0, 1, 0, 0);
        cycle("ar.s1");
        cycle("ar.s2");
        drive(0, 8'h00, 0, 0, 0, 0);
        #2;
        async_reset("ar");
        cycle("ar.release");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] opc;
            opc = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
            drive(1'($urandom_range(0, 1)), opc, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 30) == 0));
            cycle("rnd");
            if ($urandom_range(0, 250) == 0) begin
                #1;
                async_reset("rnd.rst");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_input_sequencer.md
DECODER_INPUT_SEQUENCER -- requirements
Module: decoder_input_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port nRESET, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 8, the fetched instruction byte.
REQ-004 SHALL have port opcode_valid, input, 1, meaning the opcode byte is present this cycle.
REQ-005 SHALL have port opcode_ready, output, 1, meaning the sequencer accepts an opcode this cycle.
REQ-006 SHALL have port int_req, input, 1, meaning an accepted interrupt is pending at the instruction boundary.
REQ-007 SHALL have port step_adv, input, 1, the M-cycle advance strobe.
REQ-008 SHALL have port last_cycle, input, 1, meaning the current M-cycle is the final one of the instruction.
REQ-009 SHALL have port flush, input, 1, a synchronous abort back to fetch.
REQ-010 SHALL have port a, output, 26, the dual-rail decoder input bus.
REQ-011 SHALL have ports in_exec (output, 1), step (output, 3) and seq_err (output, 1, sticky).

Function
REQ-012 SHALL form 13 logical fields f[12:0]: f0=int dispatch, f1=CB prefix, f2..f9=IR bits 7..0, f10..f12=step bits 0..2.
REQ-013 SHALL drive a[2i]=~f[i] and a[2i+1]=f[i] for every i while running, so each rail pair is exactly one-hot.
REQ-014 SHALL register a; a change caused by an edge is visible after that edge, with no combinational path from inputs to a.
REQ-015 SHALL implement the states RST_IDLE, FETCH and EXEC.
REQ-016 In RST_IDLE, the block SHALL drive a=0 (all rails low, all decoder lines inactive) and opcode_ready=0, then move to FETCH on the first edge after reset release.
REQ-017 In FETCH, opcode_ready SHALL be 1 and the handshake SHALL complete on opcode_valid&opcode_ready.
REQ-018 On handshake with opcode=0xCB and cb=0, the block SHALL set cb=1, load IR=0xCB and stay in FETCH with step=0.
REQ-019 On any other handshake, the block SHALL load IR, set int=int_req sampled on the same edge, set step=0 and enter EXEC.
REQ-020 With cb=1, a further 0xCB SHALL be treated as an ordinary CB opcode (it enters EXEC).
REQ-021 In EXEC, opcode_ready SHALL be 0, in_exec SHALL be 1, and step SHALL increment by 1 on each step_adv.
REQ-022 On step_adv&last_cycle in EXEC, the block SHALL clear cb, int and step and return to FETCH; IR SHALL hold its value.
REQ-023 On step_adv at step=7 without last_cycle, step SHALL hold at 7 and seq_err SHALL be set; seq_err clears only on reset.
REQ-024 In EXEC, last_cycle without step_adv SHALL be ignored.
REQ-025 flush SHALL have priority over all other inputs: go to FETCH and clear cb, int and step, with IR unchanged.
REQ-026 If flush coincides with a handshake, the opcode SHALL be dropped.
REQ-027 In FETCH, the block SHALL ignore step_adv and last_cycle.
REQ-028 The step output SHALL mirror f12..f10.

Reset
REQ-029 nRESET low SHALL immediately force state=RST_IDLE, IR=0x00, cb=0, int=0, step=0, seq_err=0, a=0, opcode_ready=0 and in_exec=0, including mid-instruction.
REQ-030 Deassertion SHALL take effect at the next CLK edge.

Structure
REQ-031 A shared package SHALL hold the state enum, the field index constants (F_INT, F_CB, F_IR_LO, F_STEP_LO) and NUM_FIELDS=13.
REQ-032 There SHALL be one sub-module, dual_rail_enc, mapping 13 fields plus an enable to 26 rails, with all rails low when the enable is 0.

Verification
REQ-033 Reset release, then opcode 0x3E accepted with int_req=0 -> the next cycle a=0x156AA55, in_exec=1, step=0.
REQ-034 0xCB accepted, then 0x37 accepted -> after the first edge a[3]=1, a[2]=0 and state is FETCH; after the second edge IR=0x37 in EXEC with a[3] still 1.
REQ-035 Opcode 0x00 with int_req=1, then three step_adv pulses, the third with last_cycle -> a[1]=1 during EXEC, step 0→1→2, then FETCH with a[1]=0 and a[0]=1.
REQ-036 Eight step_adv pulses with no last_cycle -> step saturates at 7 and seq_err=1 persists until nRESET.
REQ-037 flush asserted together with opcode_valid in FETCH after a CB prefix -> cb=0, the opcode is dropped, opcode_ready stays 1.
REQ-038 nRESET pulled low asynchronously mid-EXEC at step=2 -> a=0 with no clock edge, then FETCH one edge after release.
